// File: rtl/cyclic_ptr_tracker_if.sv
// Handshake/status bundle between a pointer-tracker client and cyclic_ptr_tracker.
// Latency: none, wires only.
// Backpressure: carries alloc_ready / retire_ready for valid-ready flow control.
interface cyclic_ptr_tracker_if #(
  parameter int LOG_DEPTH = 6
);
  logic                 flush;
  logic                 alloc_valid;
  logic                 alloc_ready;
  logic [LOG_DEPTH-1:0] alloc_idx;
  logic                 done_valid;
  logic [LOG_DEPTH-1:0] done_idx;
  logic                 done_err;
  logic                 retire_valid;
  logic                 retire_ready;
  logic [LOG_DEPTH-1:0] retire_idx;
  logic [LOG_DEPTH-1:0] head_idx;
  logic [LOG_DEPTH-1:0] tail_idx;
  logic [LOG_DEPTH:0]   count;
  logic                 full;
  logic                 empty;

  // Client side: requests allocations, marks completions, consumes retirements.
  modport master (
    output flush, alloc_valid, done_valid, done_idx, retire_ready,
    input  alloc_ready, alloc_idx, done_err, retire_valid, retire_idx,
           head_idx, tail_idx, count, full, empty
  );

  // Tracker side.
  modport slave (
    input  flush, alloc_valid, done_valid, done_idx, retire_ready,
    output alloc_ready, alloc_idx, done_err, retire_valid, retire_idx,
           head_idx, tail_idx, count, full, empty
  );
endinterface

// File: rtl/cyclic_ptr_tracker.sv
// Head/tail pointer manager for a cyclic table: in-order alloc, out-of-order done, in-order retire.
// Latency: outputs combinational from state; a done mark reaches retire_valid one cycle later.
// Backpressure: alloc_ready drops while full (even if retiring); retire holds until retire_ready.
module cyclic_ptr_tracker #(
  parameter int LOG_DEPTH = 6
) (
  input logic                 clk,
  input logic                 resetN,
  cyclic_ptr_tracker_if.slave bus
);
  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0]   DEPTH_CNT = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH-1:0] PTR_ONE   = LOG_DEPTH'(1);
  localparam logic [LOG_DEPTH:0]   CNT_ONE   = (LOG_DEPTH+1)'(1);

  logic [LOG_DEPTH-1:0] head_q, head_d;
  logic [LOG_DEPTH-1:0] tail_q, tail_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic [DEPTH-1:0]     done_q, done_d;
  logic                 done_err_q, done_err_d;

  logic                 full, empty;
  logic                 alloc_fire, retire_fire;
  logic [LOG_DEPTH-1:0] done_off;
  logic                 done_live, done_ok;

  assign full        = (count_q == DEPTH_CNT);
  assign empty       = (count_q == '0);
  assign alloc_fire  = bus.alloc_valid && !full;
  assign retire_fire = bus.retire_valid && bus.retire_ready;

  // Offset from head in cyclic order; the slot is live iff that offset is below count.
  // This covers both head==tail cases: count==DEPTH makes every slot live, count==0 none.
  assign done_off  = bus.done_idx - head_q;
  assign done_live = ({1'b0, done_off} < count_q);
  // A slot leaving via retire this cycle no longer accepts a completion mark.
  assign done_ok   = done_live && !(retire_fire && (bus.done_idx == head_q));

  assign bus.alloc_ready  = !full;
  assign bus.alloc_idx    = tail_q;
  assign bus.retire_valid = !empty && done_q[head_q];
  assign bus.retire_idx   = head_q;
  assign bus.head_idx     = head_q;
  assign bus.tail_idx     = tail_q;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.done_err     = done_err_q;

  // Next-state: flush wins over every handshake; otherwise apply alloc, retire and done.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    done_d     = done_q;
    done_err_d = 1'b0;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      done_d  = '0;
    end else begin
      if (alloc_fire) begin
        done_d[tail_q] = 1'b0;
        tail_d         = tail_q + PTR_ONE;
      end
      if (retire_fire) begin
        head_d = head_q + PTR_ONE;
      end
      // The tail slot is never live when alloc fires, so this cannot collide with the clear above.
      if (bus.done_valid) begin
        if (done_ok) done_d[bus.done_idx] = 1'b1;
        else         done_err_d = 1'b1;
      end
      if (alloc_fire && !retire_fire)      count_d = count_q + CNT_ONE;
      else if (!alloc_fire && retire_fire) count_d = count_q - CNT_ONE;
    end
  end

  // State registers with asynchronous active-low reset to the empty table.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      done_q     <= '0;
      done_err_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
    end
  end
endmodule

// File: tb/tb_cyclic_ptr_tracker.sv
// Directed bench for cyclic_ptr_tracker at DEPTH=8 with hand-computed expectations.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: exercises full-blocked alloc and held retire_ready.
module tb_cyclic_ptr_tracker;
  localparam int LD = 3;

  logic clk;
  logic resetN;
  int   checks;
  int   errors;

  cyclic_ptr_tracker_if #(.LOG_DEPTH(LD)) bus();

  cyclic_ptr_tracker #(.LOG_DEPTH(LD)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetN = 1'b0;
    bus.flush = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.done_valid = 1'b0;
    bus.done_idx = '0;
    bus.retire_ready = 1'b0;
    #2;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("rst_retire_valid", 32'(bus.retire_valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_head", 32'(bus.head_idx), 32'd0);
    chk("rst_tail", 32'(bus.tail_idx), 32'd0);
    chk("rst_done_err", 32'(bus.done_err), 32'd0);
    #1 resetN = 1'b1;
    tick();

    // 1: allocate three entries, completion visible one cycle later
    bus.alloc_valid = 1'b1;
    chk("t1_alloc_idx0", 32'(bus.alloc_idx), 32'd0);
    tick();
    chk("t1_alloc_idx1", 32'(bus.alloc_idx), 32'd1);
    tick();
    chk("t1_alloc_idx2", 32'(bus.alloc_idx), 32'd2);
    tick();
    bus.alloc_valid = 1'b0;
    chk("t1_tail", 32'(bus.tail_idx), 32'd3);
    chk("t1_count", 32'(bus.count), 32'd3);
    chk("t1_rv_before", 32'(bus.retire_valid), 32'd0);
    bus.done_valid = 1'b1;
    bus.done_idx = 3'd0;
    chk("t1_no_bypass", 32'(bus.retire_valid), 32'd0);
    tick();
    bus.done_valid = 1'b0;
    chk("t1_rv_after", 32'(bus.retire_valid), 32'd1);
    chk("t1_retire_idx", 32'(bus.retire_idx), 32'd0);
    chk("t1_done_err", 32'(bus.done_err), 32'd0);

    // 2: out-of-order completion, in-order retirement
    bus.done_valid = 1'b1;
    bus.done_idx = 3'd2; tick();
    bus.done_idx = 3'd1; tick();
    bus.done_idx = 3'd0; tick();
    bus.done_valid = 1'b0;
    chk("t2_idempotent_err", 32'(bus.done_err), 32'd0);
    bus.retire_ready = 1'b1;
    chk("t2_ret0", 32'(bus.retire_idx), 32'd0);
    tick();
    chk("t2_ret1", 32'(bus.retire_idx), 32'd1);
    chk("t2_count2", 32'(bus.count), 32'd2);
    chk("t2_rv1", 32'(bus.retire_valid), 32'd1);
    tick();
    chk("t2_ret2", 32'(bus.retire_idx), 32'd2);
    chk("t2_rv2", 32'(bus.retire_valid), 32'd1);
    tick();
    bus.retire_ready = 1'b0;
    chk("t2_empty", 32'(bus.empty), 32'd1);
    chk("t2_head", 32'(bus.head_idx), 32'd3);
    chk("t2_rv_empty", 32'(bus.retire_valid), 32'd0);

    // 3: fill the table from reset, blocked alloc, alloc+retire while full
    resetN = 1'b0;
    #2 resetN = 1'b1;
    bus.alloc_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("t3_full", 32'(bus.full), 32'd1);
    chk("t3_head", 32'(bus.head_idx), 32'd0);
    chk("t3_tail", 32'(bus.tail_idx), 32'd0);
    chk("t3_alloc_ready", 32'(bus.alloc_ready), 32'd0);
    chk("t3_count8", 32'(bus.count), 32'd8);
    tick();
    chk("t3_blocked_tail", 32'(bus.tail_idx), 32'd0);
    chk("t3_blocked_count", 32'(bus.count), 32'd8);
    bus.alloc_valid = 1'b0;
    bus.done_valid = 1'b1;
    bus.done_idx = 3'd0;
    tick();
    bus.done_valid = 1'b0;
    chk("t3_full_done_err", 32'(bus.done_err), 32'd0);
    chk("t3_rv", 32'(bus.retire_valid), 32'd1);
    bus.alloc_valid = 1'b1;
    bus.retire_ready = 1'b1;
    chk("t3_ar_during_retire", 32'(bus.alloc_ready), 32'd0);
    tick();
    bus.alloc_valid = 1'b0;
    bus.retire_ready = 1'b0;
    chk("t3_count7", 32'(bus.count), 32'd7);
    chk("t3_tail_unch", 32'(bus.tail_idx), 32'd0);
    chk("t3_head1", 32'(bus.head_idx), 32'd1);
    chk("t3_not_full", 32'(bus.full), 32'd0);

    // 4: wrapped live range head=6 tail=2
    bus.done_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.done_idx = 3'(i);
      tick();
    end
    bus.done_valid = 1'b0;
    bus.retire_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.retire_ready = 1'b0;
    chk("t4_head6", 32'(bus.head_idx), 32'd6);
    chk("t4_count2", 32'(bus.count), 32'd2);
    bus.alloc_valid = 1'b1;
    tick(); tick();
    bus.alloc_valid = 1'b0;
    chk("t4_tail2", 32'(bus.tail_idx), 32'd2);
    chk("t4_count4", 32'(bus.count), 32'd4);
    bus.done_valid = 1'b1;
    bus.done_idx = 3'd7;
    tick();
    chk("t4_done7_ok", 32'(bus.done_err), 32'd0);
    bus.done_idx = 3'd3;
    tick();
    bus.done_valid = 1'b0;
    chk("t4_done3_err", 32'(bus.done_err), 32'd1);
    chk("t4_err_count", 32'(bus.count), 32'd4);
    chk("t4_err_head", 32'(bus.head_idx), 32'd6);
    chk("t4_err_tail", 32'(bus.tail_idx), 32'd2);
    chk("t4_rv_head_pending", 32'(bus.retire_valid), 32'd0);
    tick();
    chk("t4_err_pulse_end", 32'(bus.done_err), 32'd0);
    bus.done_valid = 1'b1;
    bus.done_idx = 3'd6;
    tick();
    bus.done_valid = 1'b0;
    chk("t4_rv6", 32'(bus.retire_valid), 32'd1);
    bus.retire_ready = 1'b1;
    tick();
    chk("t4_ret7_idx", 32'(bus.retire_idx), 32'd7);
    chk("t4_ret7_rv", 32'(bus.retire_valid), 32'd1);
    tick();
    bus.retire_ready = 1'b0;
    chk("t4_head_wrap", 32'(bus.head_idx), 32'd0);
    chk("t4_count_after", 32'(bus.count), 32'd2);
    chk("t4_realloc_cleared", 32'(bus.retire_valid), 32'd0);
    // completion aimed at the slot being allocated this cycle
    bus.alloc_valid = 1'b1;
    bus.done_valid = 1'b1;
    bus.done_idx = 3'd2;
    tick();
    bus.alloc_valid = 1'b0;
    bus.done_valid = 1'b0;
    chk("t4_same_alloc_err", 32'(bus.done_err), 32'd1);
    chk("t4_same_alloc_tail", 32'(bus.tail_idx), 32'd3);
    // completion aimed at the slot being retired this cycle
    bus.done_valid = 1'b1;
    bus.done_idx = 3'd0;
    tick();
    chk("t4_mark0_ok", 32'(bus.done_err), 32'd0);
    bus.retire_ready = 1'b1;
    tick();
    bus.done_valid = 1'b0;
    bus.retire_ready = 1'b0;
    chk("t4_same_retire_err", 32'(bus.done_err), 32'd1);
    chk("t4_same_retire_head", 32'(bus.head_idx), 32'd1);
    chk("t4_same_retire_count", 32'(bus.count), 32'd2);

    // 5: flush with five live entries and a concurrent alloc / bad done
    bus.alloc_valid = 1'b1;
    tick(); tick(); tick();
    chk("t5_count5", 32'(bus.count), 32'd5);
    bus.flush = 1'b1;
    bus.done_valid = 1'b1;
    bus.done_idx = 3'd7;
    chk("t5_ar_preflush", 32'(bus.alloc_ready), 32'd1);
    tick();
    bus.flush = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.done_valid = 1'b0;
    chk("t5_head", 32'(bus.head_idx), 32'd0);
    chk("t5_tail", 32'(bus.tail_idx), 32'd0);
    chk("t5_count", 32'(bus.count), 32'd0);
    chk("t5_empty", 32'(bus.empty), 32'd1);
    chk("t5_no_err", 32'(bus.done_err), 32'd0);

    // 6: asynchronous reset with a retirable head
    bus.alloc_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.alloc_valid = 1'b0;
    bus.done_valid = 1'b1;
    bus.done_idx = 3'd0;
    tick();
    bus.done_valid = 1'b0;
    chk("t6_count4", 32'(bus.count), 32'd4);
    chk("t6_rv_pre", 32'(bus.retire_valid), 32'd1);
    #2 resetN = 1'b0;
    bus.retire_ready = 1'b1;
    #1;
    chk("t6_rv", 32'(bus.retire_valid), 32'd0);
    chk("t6_count", 32'(bus.count), 32'd0);
    chk("t6_empty", 32'(bus.empty), 32'd1);
    chk("t6_tail", 32'(bus.tail_idx), 32'd0);
    tick();
    chk("t6_held_count", 32'(bus.count), 32'd0);
    resetN = 1'b1;
    bus.retire_ready = 1'b0;
    tick();
    chk("t6_after_empty", 32'(bus.empty), 32'd1);
    chk("t6_after_ar", 32'(bus.alloc_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
